// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci pair serializer: word, pair and half-select encodings.
package fib_pkg;

  localparam int unsigned FIB_W = 16;

  typedef logic [FIB_W-1:0] fib_word_t;

  typedef struct packed {
    fib_word_t first;
    fib_word_t second;
  } fib_pair_t;

  typedef enum logic {
    SelFirst  = 1'b0,
    SelSecond = 1'b1
  } sel_e;

endpackage

// File: rtl/fib_pair_fifo.sv
// Synchronous FIFO of fib_pair_t; push is ignored when full, pop is ignored when empty.
module fib_pair_fifo
  import fib_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  fib_pair_t wdata_i,
  input  logic      pop_i,
  output fib_pair_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);
  localparam logic [AW:0] CntOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne = AW'(1);

  fib_pair_t       mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntFull);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PtrOne;
    if (do_pop)  rptr_d = rptr_q + PtrOne;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fib_pair_serializer.sv
// Accepts 16-bit word pairs and emits them one word per handshake, first then second.
// Optional recurrence checker enabled by defining FIB_SERIALIZER_CHECK_EN.
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [FIB_W-1:0] in_first_i,
  input  logic [FIB_W-1:0] in_second_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [FIB_W-1:0] out_data_o,
  output logic             err_o
);

  fib_pair_t head;
  fib_pair_t wdata;
  logic      full, empty, push, pop, out_hs;
  sel_e      sel_q, sel_d;

  assign wdata       = '{first: in_first_i, second: in_second_i};
  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign push        = in_valid_i && in_ready_o;
  assign out_hs      = out_valid_o && out_ready_i;
  assign pop         = out_hs && (sel_q == SelSecond);

  fib_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) sel_q <= SelFirst;
    else       sel_q <= sel_d;
  end

  always_comb begin
    sel_d = sel_q;
    if (out_hs) begin
      unique case (sel_q)
        SelFirst:  sel_d = SelSecond;
        SelSecond: sel_d = SelFirst;
        default:   sel_d = SelFirst;
      endcase
    end
  end

  always_comb begin
    out_data_o = (sel_q == SelSecond) ? head.second : head.first;
  end

`ifdef FIB_SERIALIZER_CHECK_EN
  fib_word_t  prev1_q, prev2_q;
  logic [1:0] seen_q;
  logic       err_q;

  // seen saturates at 2: from then on every emitted word must be the sum of the two before it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev1_q <= '0;
      prev2_q <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
    end else if (out_hs) begin
      prev2_q <= prev1_q;
      prev1_q <= out_data_o;
      if (seen_q != 2'd2) seen_q <= seen_q + 2'd1;
      if ((seen_q == 2'd2) && (out_data_o != fib_word_t'(prev1_q + prev2_q))) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Scoreboard bench for fib_pair_serializer: stimulus queues expected words, a monitor checks them.
module tb_fib_pair_serializer;
  import fib_pkg::*;

`ifdef FIB_SERIALIZER_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst;
  logic      in_valid, in_ready, out_valid, out_ready, err;
  fib_word_t in_first, in_second, out_data;

  int        n_tests = 0;
  int        n_fail  = 0;
  fib_word_t exp_q[$];

  fib_word_t fa[5] = '{16'd13, 16'd34, 16'd89,  16'd233, 16'd610};
  fib_word_t fb[5] = '{16'd21, 16'd55, 16'd144, 16'd377, 16'd987};

  always #5 clk = ~clk;

  fib_pair_serializer #(
    .DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_first_i  (in_first),
    .in_second_i (in_second),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .err_o       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare every output handshake against the scoreboard, and check stall stability.
  logic      stall_q = 1'b0;
  fib_word_t stall_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && out_valid) check("stall_hold", out_data, stall_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d, expected no output", out_data);
        end else begin
          check("out_order", out_data, exp_q.pop_front());
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_pair(input fib_word_t a, input fib_word_t b);
    in_first  = a;
    in_second = b;
    in_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(a);
        exp_q.push_back(b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL push_timeout: got in_ready=0 for 50 cycles, expected acceptance");
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
    @(posedge clk); #1;
  endtask

  initial begin
    int idx;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_first = '0; in_second = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_err", err, 0);
    @(posedge clk); #1;

    // Basic order and first-word latency
    out_ready = 1'b1;
    push_pair(16'd1, 16'd1);
    @(negedge clk);
    check("latency_out_valid", out_valid, 1);
    @(posedge clk); #1;
    push_pair(16'd2, 16'd3);
    push_pair(16'd5, 16'd8);
    drain();
    check("basic_err", err, 0);

    // Backpressure until full, then release
    do_reset();
    out_ready = 1'b0;
    idx = 0;
    in_first = fa[0]; in_second = fb[0]; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(fa[idx]);
        exp_q.push_back(fb[idx]);
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 5) begin
        in_first = fa[idx]; in_second = fb[idx];
      end
    end
    in_valid = 1'b0;
    check("full_accepted", idx, 4);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("full_no_pop_sel0", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_no_bypass", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_reassert", in_ready, 1);
    @(posedge clk); #1;
    drain();

    // Stall mid-pair: out_ready 1,0,0,1
    do_reset();
    out_ready = 1'b0;
    push_pair(16'd13, 16'd21);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("stall_data_1", out_data, 21);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_data_2", out_data, 21);
    check("stall_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_done_empty", out_valid, 0);
    @(posedge clk); #1;

    // 16-bit wrap-around keeps the recurrence intact
    do_reset();
    out_ready = 1'b1;
    push_pair(16'd28657, 16'd46368);
    push_pair(16'd9489, 16'd55857);
    drain();
    check("wrap_err", err, 0);

    // Recurrence violation: 1,1,2,4 breaks at the 4th word; err stays set
    do_reset();
    out_ready = 1'b1;
    push_pair(16'd1, 16'd1);
    push_pair(16'd2, 16'd4);
    drain();
    check("chk_err_set", err, ChkEn);
    push_pair(16'd6, 16'd10);
    drain();
    check("chk_err_sticky", err, ChkEn);
    do_reset();
    @(negedge clk);
    check("chk_err_cleared", err, 0);
    @(posedge clk); #1;

    // Reset mid-operation with sel = 1 and three pairs queued
    do_reset();
    out_ready = 1'b0;
    push_pair(16'd5, 16'd8);
    push_pair(16'd13, 16'd21);
    push_pair(16'd34, 16'd55);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_err", err, 0);
    @(posedge clk); #1;
    push_pair(16'd1, 16'd1);
    @(negedge clk);
    check("midrst_first_word", out_data, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/fib_pair_serializer.md
Name: fib_pair_serializer

Overview:
- Downstream stage of the double-rate Fibonacci generator: accepts one pair of 16-bit words per handshake and emits them one word per handshake, first word then second.
- A small pair FIFO decouples the double-rate producer from a single-rate consumer and absorbs backpressure.
- Optionally checks that the emitted stream obeys the Fibonacci recurrence modulo 2^16.

Parameters:
- DEPTH, 4, FIFO capacity in pairs; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers a pair.
- in_ready  output  1  block accepts the pair this cycle.
- in_first  input  16  earlier word of the pair.
- in_second  input  16  later word of the pair.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  16  serialized word.
- err  output  1  sticky recurrence-violation flag; constant 0 when the checker is compiled out.

Behaviour:
- Reset (rst high at posedge): FIFO empty, count = 0, half-select sel = 0, err = 0. Outputs after reset: in_ready = 1, out_valid = 0, out_data don't-care.
- Push: when in_valid && in_ready, {in_first, in_second} is written at the write pointer.
- Pop and serialization:
  - out_valid = (count != 0).
  - out_data = sel ? head.second : head.first.
  - On out_valid && out_ready with sel = 0: sel <= 1 and the head is not popped.
  - On the same handshake with sel = 1: sel <= 0 and the head is popped.
- Handshake rules:
  - in_ready = (count != DEPTH). There is no bypass: a pop in the same cycle does not enable a push when full.
  - Producer keeps in_first, in_second and in_valid stable until accepted. Consumer sees out_data stable while out_valid && !out_ready.
- Latency: a pair pushed into an empty FIFO is visible on out_data the next cycle. Each pair occupies 2 output handshakes, so the maximum sustained rate is 1 pair per 2 cycles.
- Simultaneous push and pop (sel = 1): count is unchanged and both pointers advance.
- Pointers: log2(DEPTH) bits, wrap naturally. count is log2(DEPTH)+1 bits.
- Full: in_ready = 0, no write, content preserved.
- Empty: out_valid = 0. out_ready is ignored and sel does not change.
- Reset mid-operation discards all stored pairs and clears sel and err. The first post-reset output is the first word of the first post-reset pair.
- Arithmetic: all data is unsigned 16-bit, no widening.

Optional Feature:
- Macro FIB_SERIALIZER_CHECK_EN.
- When defined, the block keeps prev1 and prev2 (the last two emitted words) and seen, a 2-bit saturating count of handshaked outputs.
  - On each output handshake with seen == 2: if out_data != (prev1 + prev2) mod 2^16, err <= 1 (sticky until rst).
  - Every handshake shifts prev2 <= prev1 and prev1 <= out_data.
  - rst clears seen, prev1, prev2 and err.
- When not defined: no checker registers, err tied to 0, no other behaviour difference.

Decomposition:
- Package fib_pkg:
  - typedef fib_word_t (logic [15:0]).
  - typedef fib_pair_t (packed struct: first, second).
  - localparam FIB_W = 16.
- Sub-module fib_pair_fifo: parameterized synchronous FIFO of fib_pair_t with push/pop/full/empty.
- fib_pair_serializer owns sel, the handshakes and the optional checker.

Test Plan:
- Basic order: push (1,1), (2,3), (5,8) with out_ready = 1 → out_data 1,1,2,3,5,8 on consecutive handshakes; first out_valid 1 cycle after the first push; err = 0.
- Backpressure/full (DEPTH = 4): out_ready = 0, in_valid = 1 continuously → exactly 4 pairs accepted, then in_ready = 0. Release out_ready → 8 words in order; in_ready reasserts after the first pop.
- Stall mid-pair: out_ready toggles 1,0,0,1 on pair (13,21) → out_data holds 21 across the stalled cycles; sel does not advance while stalled.
- Wrap-around: push (28657,46368) then (9489,55857), i.e. 16-bit overflow → outputs unchanged, checker raises no error (75025 mod 65536 = 9489).
- Checker (macro on): push (1,1), (2,4) → err rises on the 4th output handshake and stays 1 through further correct traffic until rst.
- Reset mid-operation: 3 pairs queued, sel = 1, assert rst 1 cycle → out_valid = 0, in_ready = 1, err = 0; next pair (1,1) emits 1 first.
